// File: rtl/dadda_mac_acc.sv
// dadda_mac_acc: frame accumulator placed after the 16x16 Dadda multiplier.
// Sums LEN consecutive unsigned products into an ACC_W-bit accumulator and
// presents each frame sum, with a sticky overflow flag, on a valid/ready port.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   clear      synchronous frame abort (keeps out_sum/out_ovf)
//   in_valid   in_prod carries a product
//   in_ready   block accepts a product this cycle (high while accumulating)
//   in_prod    unsigned product, IN_W bits
//   out_valid  frame result pending
//   out_ready  consumer takes the result
//   out_sum    frame sum, ACC_W bits
//   out_ovf    at least one overflow happened in the frame
//   busy       mid-frame or result pending
module dadda_mac_acc #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN   = 4,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned CntW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic {StAcc, StDone} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_q;

  logic [ACC_W:0]   sum_ext;
  logic             ovf_step;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             last;

  // One extra bit catches the carry out of the accumulator.
  always_comb begin
    sum_ext  = {1'b0, acc_q} + {{(ACC_W + 1 - IN_W){1'b0}}, in_prod};
    ovf_step = sum_ext[ACC_W];
    acc_next = (ovf_step && SAT) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    ovf_next = ovf_q | ovf_step;
    last     = (cnt_q == CntW'(LEN - 1));
  end

  assign in_ready = (state_q == StAcc);
  assign busy     = (cnt_q != '0) || out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      // Abort drops any transfer in this cycle; last result stays visible.
      state_q   <= StAcc;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StAcc: begin
          if (in_valid) begin
            if (last) begin
              out_sum   <= acc_next;
              out_ovf   <= ovf_next;
              out_valid <= 1'b1;
              acc_q     <= '0;
              cnt_q     <= '0;
              ovf_q     <= 1'b0;
              state_q   <= StDone;
            end else begin
              acc_q <= acc_next;
              ovf_q <= ovf_next;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          // No bypass: in_ready returns only after the handshake edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StAcc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Bench for dadda_mac_acc: five instances with different ACC_W/LEN/SAT share
// one stimulus stream; a frame-level model predicts every output each cycle.
module tb_dadda_mac_acc;

  localparam int NI = 5;
  localparam int P_AW  [NI] = '{40, 32, 32, 40, 40};
  localparam int P_LEN [NI] = '{3, 2, 2, 4, 1};
  localparam int P_SAT [NI] = '{1, 1, 0, 0, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_prod = '0;

  logic        d_rdy [NI];
  logic        d_vld [NI];
  logic        d_ovf [NI];
  logic        d_bsy [NI];
  logic [63:0] d_sum [NI];

  logic [39:0] s0, s3, s4;
  logic [31:0] s1, s2;

  assign d_sum[0] = {24'b0, s0};
  assign d_sum[1] = {32'b0, s1};
  assign d_sum[2] = {32'b0, s2};
  assign d_sum[3] = {24'b0, s3};
  assign d_sum[4] = {24'b0, s4};

  always #5 clk = ~clk;

  dadda_mac_acc #(.IN_W(32), .ACC_W(40), .LEN(3), .SAT(1'b1)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy[0]),
    .in_prod(in_prod), .out_valid(d_vld[0]), .out_ready(out_ready), .out_sum(s0),
    .out_ovf(d_ovf[0]), .busy(d_bsy[0]));
  dadda_mac_acc #(.IN_W(32), .ACC_W(32), .LEN(2), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy[1]),
    .in_prod(in_prod), .out_valid(d_vld[1]), .out_ready(out_ready), .out_sum(s1),
    .out_ovf(d_ovf[1]), .busy(d_bsy[1]));
  dadda_mac_acc #(.IN_W(32), .ACC_W(32), .LEN(2), .SAT(1'b0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy[2]),
    .in_prod(in_prod), .out_valid(d_vld[2]), .out_ready(out_ready), .out_sum(s2),
    .out_ovf(d_ovf[2]), .busy(d_bsy[2]));
  dadda_mac_acc #(.IN_W(32), .ACC_W(40), .LEN(4), .SAT(1'b0)) u3 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy[3]),
    .in_prod(in_prod), .out_valid(d_vld[3]), .out_ready(out_ready), .out_sum(s3),
    .out_ovf(d_ovf[3]), .busy(d_bsy[3]));
  dadda_mac_acc #(.IN_W(32), .ACC_W(40), .LEN(1), .SAT(1'b1)) u4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy[4]),
    .in_prod(in_prod), .out_valid(d_vld[4]), .out_ready(out_ready), .out_sum(s4),
    .out_ovf(d_ovf[4]), .busy(d_bsy[4]));

  // Frame-level model: running sum, products seen, sticky overflow, pending result.
  logic [63:0] m_acc  [NI];
  logic [63:0] m_osum [NI];
  int          m_cnt  [NI];
  bit          m_ovf  [NI];
  bit          m_pend [NI];
  bit          m_oovf [NI];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, got, exp);
    end
  endtask

  task automatic model_step();
    logic [63:0] mask, s, nv;
    bit of;
    for (int i = 0; i < NI; i++) begin
      mask = (64'd1 << P_AW[i]) - 64'd1;
      if (rst) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
        m_osum[i] = 0; m_oovf[i] = 0;
      end else if (clear) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (out_ready) m_pend[i] = 0;
      end else if (in_valid) begin
        s  = m_acc[i] + {32'b0, in_prod};
        of = (s > mask);
        nv = of ? ((P_SAT[i] != 0) ? mask : (s & mask)) : s;
        if (m_cnt[i] == P_LEN[i] - 1) begin
          m_osum[i] = nv; m_oovf[i] = m_ovf[i] | of; m_pend[i] = 1;
          m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
        end else begin
          m_acc[i] = nv; m_ovf[i] = m_ovf[i] | of; m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      chk("in_ready", i, {63'b0, d_rdy[i]}, {63'b0, !m_pend[i]});
      chk("out_valid", i, {63'b0, d_vld[i]}, {63'b0, m_pend[i]});
      chk("busy", i, {63'b0, d_bsy[i]}, {63'b0, (m_cnt[i] != 0) || m_pend[i]});
      chk("out_sum", i, d_sum[i], m_osum[i]);
      chk("out_ovf", i, {63'b0, d_ovf[i]}, {63'b0, m_oovf[i]});
    end
  endtask

  // Advance one clock with the inputs currently driven, then check outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic feed(input logic [31:0] p);
    in_valid = 1'b1; in_prod = p;
    cycle();
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_acc[i] = 0; m_osum[i] = 0; m_cnt[i] = 0;
      m_ovf[i] = 0; m_pend[i] = 0; m_oovf[i] = 0;
    end
    @(negedge clk);
    do_reset();
    cycle();
    chk("lit_reset_in_ready", 0, {63'b0, d_rdy[0]}, 64'd1);
    chk("lit_reset_out_valid", 0, {63'b0, d_vld[0]}, 64'd0);
    chk("lit_reset_busy", 0, {63'b0, d_bsy[0]}, 64'd0);
    chk("lit_reset_sum", 0, d_sum[0], 64'd0);

    // Basic frame on the LEN=3 instance.
    out_ready = 1'b1;
    feed(32'd361935522);
    feed(32'd1030738330);
    feed(32'd4294770690);
    chk("lit_basic_valid", 0, {63'b0, d_vld[0]}, 64'd1);
    chk("lit_basic_sum", 0, d_sum[0], 64'd5687444542);
    chk("lit_basic_ovf", 0, {63'b0, d_ovf[0]}, 64'd0);
    chk("lit_basic_rdy0", 0, {63'b0, d_rdy[0]}, 64'd0);
    in_valid = 1'b0;
    cycle();
    chk("lit_basic_rdy1", 0, {63'b0, d_rdy[0]}, 64'd1);

    // Backpressure on the LEN=2 instance.
    do_reset();
    feed(32'd10);
    feed(32'd20);
    chk("lit_bp_sum", 1, d_sum[1], 64'd30);
    for (int k = 0; k < 5; k++) begin
      feed(32'd99);
      chk("lit_bp_hold", 1, d_sum[1], 64'd30);
      chk("lit_bp_rdy", 1, {63'b0, d_rdy[1]}, 64'd0);
    end
    out_ready = 1'b1;
    feed(32'd99);
    chk("lit_bp_after_hs", 1, {63'b0, d_vld[1]}, 64'd0);
    feed(32'd99);
    feed(32'd1);
    chk("lit_bp_next_sum", 1, d_sum[1], 64'd100);

    // Overflow: saturating vs wrapping 32-bit accumulators.
    do_reset();
    out_ready = 1'b1;
    feed(32'hFFFF_FFFF);
    feed(32'hFFFF_FFFF);
    chk("lit_ovf_sat_sum", 1, d_sum[1], 64'hFFFF_FFFF);
    chk("lit_ovf_sat_flag", 1, {63'b0, d_ovf[1]}, 64'd1);
    chk("lit_ovf_wrap_sum", 2, d_sum[2], 64'hFFFF_FFFE);
    chk("lit_ovf_wrap_flag", 2, {63'b0, d_ovf[2]}, 64'd1);
    in_valid = 1'b0;
    cycle();
    feed(32'd1);
    feed(32'd2);
    chk("lit_ovf_next_sum", 2, d_sum[2], 64'd3);
    chk("lit_ovf_next_flag", 1, {63'b0, d_ovf[1]}, 64'd0);

    // Clear mid-frame on the LEN=4 instance.
    do_reset();
    out_ready = 1'b1;
    feed(32'd5);
    feed(32'd6);
    clear = 1'b1;
    feed(32'd7);
    clear = 1'b0;
    chk("lit_clr_busy", 3, {63'b0, d_bsy[3]}, 64'd0);
    for (int k = 0; k < 4; k++) feed(32'd1);
    chk("lit_clr_sum", 3, d_sum[3], 64'd4);
    chk("lit_clr_valid", 3, {63'b0, d_vld[3]}, 64'd1);

    // Reset while a result is pending, with clear/out_ready also high.
    do_reset();
    feed(32'd3);
    feed(32'd4);
    chk("lit_rd_pending", 1, {63'b0, d_vld[1]}, 64'd1);
    in_valid = 1'b1; clear = 1'b1; out_ready = 1'b1; rst = 1'b1;
    cycle();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    chk("lit_rd_valid", 1, {63'b0, d_vld[1]}, 64'd0);
    chk("lit_rd_sum", 1, d_sum[1], 64'd0);
    chk("lit_rd_ovf", 1, {63'b0, d_ovf[1]}, 64'd0);
    chk("lit_rd_rdy", 1, {63'b0, d_rdy[1]}, 64'd1);
    chk("lit_rd_busy", 1, {63'b0, d_bsy[1]}, 64'd0);

    // LEN=1 throughput: one result every other cycle.
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk("lit_l1_rdy1", 4, {63'b0, d_rdy[4]}, 64'd1);
      feed(32'(k));
      chk("lit_l1_valid", 4, {63'b0, d_vld[4]}, 64'd1);
      chk("lit_l1_sum", 4, d_sum[4], 64'(k));
      chk("lit_l1_rdy0", 4, {63'b0, d_rdy[4]}, 64'd0);
      cycle();
    end

    // Random traffic, with extreme products mixed in to exercise overflow.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 3))
        0: in_prod = 32'hFFFF_FFFF;
        1: in_prod = $urandom_range(0, 15);
        default: in_prod = $urandom;
      endcase
      cycle();
    end
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
